dmem_arbiter: RTL

Two-port arbiter sharing the single data-memory / memory-mapped-I/O port between the CPU load/store path and an auxiliary bus master (program loader or debug DMA). Sits between the CPU's execute stage (address from the ALU, write data from the second source register) and the data memory. It issues at most one access per cycle. It returns read data one cycle after issue with a valid strobe, and stalls the CPU while the auxiliary master owns the port.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arb_starve.sv | 47 ++++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The grant encoding doubles as the read-return tag.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_AUX  = 2'd2
  } grantT;

  localparam logic [3:0] IO_BASE_NIB_DEFAULT = 4'hF;
  localparam int         STARVE_CNT_W        = 4;

endpackage

// File: rtl/dmem_arb_starve.sv
// Aux starvation guard: counts consecutive denied aux cycles and raises
// forceAux once the limit is hit, holding it until aux is served.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic auxReq,
  input  logic auxGranted,
  output logic forceAux
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cntReg, cntNext;
  logic                    forceReg, forceNext;

  always_comb begin
    cntNext   = cntReg;
    forceNext = forceReg;
    if (auxGranted || !auxReq) begin
      cntNext = '0;
    end else if (cntReg != '1) begin
      cntNext = cntReg + 1'b1;
    end
    if (auxGranted) begin
      forceNext = 1'b0;
    end else if (cntNext == LIMIT_C) begin
      forceNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cntReg   <= '0;
      forceReg <= 1'b0;
    end else begin
      cntReg   <= cntNext;
      forceReg <= forceNext;
    end
  end

  assign forceAux = forceReg;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory/MMIO port between the CPU and an aux master.
// Optional starvation guard for aux is built when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int         DBITS        = 32,
  parameter int         STARVE_LIMIT = 4,
  parameter logic [3:0] IO_BASE_NIB  = IO_BASE_NIB_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DBITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_wdata,
  output logic             cpu_stall,
  output logic [DBITS-1:0] cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             aux_req,
  input  logic             aux_we,
  input  logic [DBITS-1:0] aux_addr,
  input  logic [DBITS-1:0] aux_wdata,
  output logic             aux_gnt,
  output logic [DBITS-1:0] aux_rdata,
  output logic             aux_rvalid,
  output logic             aux_err,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata
);

  grantT grant;
  grantT rdTagReg, rdTagNext;
  logic  forceAux;
  logic  auxGranted;
  logic  grantedWe;
  logic  drop;

  assign auxGranted = (grant == GNT_AUX);

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uStarve (
    .clk       (clk),
    .reset     (reset),
    .auxReq    (aux_req),
    .auxGranted(auxGranted),
    .forceAux  (forceAux)
  );
`else
  // Strict CPU priority; the limit parameter only matters with the guard built.
  assign forceAux = 1'b0 & (STARVE_LIMIT == 0);
`endif

  always_comb begin
    grant = GNT_NONE;
    if (aux_req && (forceAux || !cpu_req)) begin
      grant = GNT_AUX;
    end else if (cpu_req) begin
      grant = GNT_CPU;
    end
  end

  always_comb begin
    grantedWe = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_CPU: begin
        grantedWe = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      GNT_AUX: begin
        grantedWe = aux_we;
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
      end
      default: ;
    endcase
  end

  // Aux may read I/O registers but never write them.
  assign drop      = auxGranted && aux_we && (aux_addr[DBITS-1 -: 4] == IO_BASE_NIB);
  assign mem_we    = grantedWe && !drop;
  assign aux_err   = drop;
  assign cpu_stall = cpu_req && (grant != GNT_CPU);
  assign aux_gnt   = aux_req && auxGranted;

  assign rdTagNext = (grant != GNT_NONE && !grantedWe) ? grant : GNT_NONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdTagReg <= GNT_NONE;
    end else begin
      rdTagReg <= rdTagNext;
    end
  end

  assign cpu_rvalid = (rdTagReg == GNT_CPU);
  assign aux_rvalid = (rdTagReg == GNT_AUX);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign aux_rdata  = aux_rvalid ? mem_rdata : '0;

endmodule
